cv32e40p_if_id_pipe_nmr: RTL and testbench

- Parametrised N-modular-redundant IF/ID pipeline register. Sits between the aligner/compressed decoder outputs and the ID stage.
- Holds NUM_REPLICAS copies of the IF/ID payload: valid, instr, compressed, illegal_c, fetch_failed and pc.
- Adds bitwise majority voting, per-replica fault flags, optional in-place scrubbing, a saturating error counter, and a fault-injection port for verification.
- Generalises the fixed 1-or-3-copy IF/ID register to any odd replica count.

---
 rtl/cv32e40p_if_id_pipe_nmr.sv | 129 ++++++++++++
 tb/tb_cv32e40p_if_id_pipe_nmr.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_if_id_pipe_nmr.sv
// N-modular-redundant IF/ID pipeline register with bitwise majority voting,
// per-replica fault flags, optional scrubbing, error counting and fault injection.
module cv32e40p_if_id_pipe_nmr #(
    parameter int NUM_REPLICAS = 3,
    parameter int VOTE_OUT     = 1,
    parameter int SCRUB_EN     = 1,
    parameter int ERR_CNT_W    = 8,
    parameter int INJECT_EN    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         if_valid_i,
    input  logic                         instr_valid_i,
    input  logic                         clear_instr_valid_i,
    input  logic [31:0]                  instr_rdata_i,
    input  logic                         is_compressed_i,
    input  logic                         illegal_c_insn_i,
    input  logic                         fetch_failed_i,
    input  logic [31:0]                  pc_if_i,
    output logic [NUM_REPLICAS-1:0]      instr_valid_id_o,
    output logic [NUM_REPLICAS*32-1:0]   instr_rdata_id_o,
    output logic [NUM_REPLICAS-1:0]      is_compressed_id_o,
    output logic [NUM_REPLICAS-1:0]      illegal_c_insn_id_o,
    output logic [NUM_REPLICAS-1:0]      is_fetch_failed_o,
    output logic [NUM_REPLICAS*32-1:0]   pc_id_o,
    output logic [NUM_REPLICAS-1:0]      fault_replica_o,
    output logic                         mismatch_o,
    output logic                         uncorrectable_o,
    output logic                         uncorrectable_sticky_o,
    output logic [ERR_CNT_W-1:0]         err_cnt_o,
    input  logic                         err_cnt_clr_i,
    input  logic                         inject_valid_i,
    input  logic [$clog2(NUM_REPLICAS):0] inject_replica_i,
    input  logic [67:0]                  inject_mask_i
);

    localparam int PW = 68;
    localparam int IW = $clog2(NUM_REPLICAS) + 1;

    // Payload layout: {valid, instr[31:0], compressed, illegal_c, fetch_failed, pc[31:0]}
    localparam int B_VALID = 67;
    localparam int B_COMPR = 34;
    localparam int B_ILL   = 33;
    localparam int B_FF    = 32;

    logic [PW-1:0]           rep_q [NUM_REPLICAS];
    logic [PW-1:0]           rep_d [NUM_REPLICAS];
    logic [PW-1:0]           out_sel [NUM_REPLICAS];
    logic [PW-1:0]           voted;
    logic [PW-1:0]           load_word;
    logic [NUM_REPLICAS-1:0] inj_hit;
    logic                    load;
    logic [ERR_CNT_W-1:0]    err_cnt_q;
    logic                    sticky_q;

    function automatic logic majority(input logic [NUM_REPLICAS-1:0] bits);
        int ones;
        ones = 0;
        for (int i = 0; i < NUM_REPLICAS; i++) begin
            if (bits[i]) ones++;
        end
        return (ones > NUM_REPLICAS / 2);
    endfunction

    for (genvar b = 0; b < PW; b++) begin : g_vote
        logic [NUM_REPLICAS-1:0] column;
        for (genvar k = 0; k < NUM_REPLICAS; k++) begin : g_col
            assign column[k] = rep_q[k][b];
        end
        assign voted[b] = majority(column);
    end

    assign load      = if_valid_i & instr_valid_i;
    assign load_word = {1'b1, instr_rdata_i, is_compressed_i, illegal_c_insn_i, 1'b0, pc_if_i};

    for (genvar k = 0; k < NUM_REPLICAS; k++) begin : g_rep
        assign inj_hit[k]         = (INJECT_EN != 0) && inject_valid_i && (inject_replica_i == IW'(k));
        assign fault_replica_o[k] = (rep_q[k] != voted);
        assign out_sel[k]         = (VOTE_OUT != 0) ? voted : rep_q[k];

        assign instr_valid_id_o[k]         = out_sel[k][B_VALID];
        assign instr_rdata_id_o[k*32 +: 32] = out_sel[k][66:35];
        assign is_compressed_id_o[k]       = out_sel[k][B_COMPR];
        assign illegal_c_insn_id_o[k]      = out_sel[k][B_ILL];
        assign is_fetch_failed_o[k]        = out_sel[k][B_FF];
        assign pc_id_o[k*32 +: 32]          = out_sel[k][31:0];
    end

    always_comb begin
        for (int k = 0; k < NUM_REPLICAS; k++) begin
            rep_d[k] = (SCRUB_EN != 0) ? voted : rep_q[k];
            if (load) begin
                rep_d[k] = load_word;
            end else if (clear_instr_valid_i) begin
                rep_d[k][B_VALID] = 1'b0;
                rep_d[k][B_FF]    = fetch_failed_i;
            end
            // Injection lands on top of the normal next state so it survives a load.
            if (inj_hit[k]) rep_d[k] = rep_d[k] ^ inject_mask_i;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_REPLICAS; k++) begin
            if (rst) rep_q[k] <= '0;
            else     rep_q[k] <= rep_d[k];
        end
    end

    assign mismatch_o      = |fault_replica_o;
    assign uncorrectable_o = mismatch_o & (&fault_replica_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
            sticky_q  <= 1'b0;
        end else if (err_cnt_clr_i) begin
            err_cnt_q <= '0;
            sticky_q  <= 1'b0;
        end else begin
            if (mismatch_o && (err_cnt_q != {ERR_CNT_W{1'b1}})) err_cnt_q <= err_cnt_q + 1'b1;
            if (uncorrectable_o) sticky_q <= 1'b1;
        end
    end

    assign err_cnt_o              = err_cnt_q;
    assign uncorrectable_sticky_o = sticky_q;

endmodule

// File: tb/tb_cv32e40p_if_id_pipe_nmr.sv
// Bench for the NMR IF/ID register: a scrubbing raw-output N=3 instance and a
// non-scrubbing voted-output N=5 instance, both against a replica-array model.
module tb_cv32e40p_if_id_pipe_nmr;

    logic         clk = 1'b0;
    logic         rst, if_valid, instr_valid, clear, compr, illegal, ff, err_clr, inj_v;
    logic [31:0]  instr, pc;
    logic [3:0]   inj_rep;
    logic [67:0]  inj_mask;

    logic [2:0]   a_valid, a_compr, a_ill, a_ff, a_fault;
    logic [95:0]  a_instr, a_pc;
    logic         a_mis, a_unc, a_stk;
    logic [7:0]   a_cnt;

    logic [4:0]   b_valid, b_compr, b_ill, b_ff, b_fault;
    logic [159:0] b_instr, b_pc;
    logic         b_mis, b_unc, b_stk;
    logic [1:0]   b_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cv32e40p_if_id_pipe_nmr #(.NUM_REPLICAS(3), .VOTE_OUT(0), .SCRUB_EN(1), .ERR_CNT_W(8), .INJECT_EN(1)) dut_a (
        .clk(clk), .rst(rst), .if_valid_i(if_valid), .instr_valid_i(instr_valid),
        .clear_instr_valid_i(clear), .instr_rdata_i(instr), .is_compressed_i(compr),
        .illegal_c_insn_i(illegal), .fetch_failed_i(ff), .pc_if_i(pc),
        .instr_valid_id_o(a_valid), .instr_rdata_id_o(a_instr), .is_compressed_id_o(a_compr),
        .illegal_c_insn_id_o(a_ill), .is_fetch_failed_o(a_ff), .pc_id_o(a_pc),
        .fault_replica_o(a_fault), .mismatch_o(a_mis), .uncorrectable_o(a_unc),
        .uncorrectable_sticky_o(a_stk), .err_cnt_o(a_cnt), .err_cnt_clr_i(err_clr),
        .inject_valid_i(inj_v), .inject_replica_i(inj_rep[2:0]), .inject_mask_i(inj_mask));

    cv32e40p_if_id_pipe_nmr #(.NUM_REPLICAS(5), .VOTE_OUT(1), .SCRUB_EN(0), .ERR_CNT_W(2), .INJECT_EN(1)) dut_b (
        .clk(clk), .rst(rst), .if_valid_i(if_valid), .instr_valid_i(instr_valid),
        .clear_instr_valid_i(clear), .instr_rdata_i(instr), .is_compressed_i(compr),
        .illegal_c_insn_i(illegal), .fetch_failed_i(ff), .pc_if_i(pc),
        .instr_valid_id_o(b_valid), .instr_rdata_id_o(b_instr), .is_compressed_id_o(b_compr),
        .illegal_c_insn_id_o(b_ill), .is_fetch_failed_o(b_ff), .pc_id_o(b_pc),
        .fault_replica_o(b_fault), .mismatch_o(b_mis), .uncorrectable_o(b_unc),
        .uncorrectable_sticky_o(b_stk), .err_cnt_o(b_cnt), .err_cnt_clr_i(err_clr),
        .inject_valid_i(inj_v), .inject_replica_i(inj_rep), .inject_mask_i(inj_mask));

    // Model: per instance, an array of replica payloads plus counter and sticky flag.
    int          nrep [2]   = '{3, 5};
    int          scrub [2]  = '{1, 0};
    int          vout [2]   = '{0, 1};
    int          cmax [2]   = '{255, 3};
    logic [67:0] m [2][7];
    int          cnt [2];
    logic        stk [2];

    function automatic logic [67:0] vote(input int d);
        logic [67:0] v;
        int ones;
        for (int b = 0; b < 68; b++) begin
            ones = 0;
            for (int k = 0; k < nrep[d]; k++) ones += int'(m[d][k][b]);
            v[b] = (2 * ones > nrep[d]);
        end
        return v;
    endfunction

    task automatic model_step();
        logic [67:0] v, nxt;
        logic        mis, anyeq;
        int          ridx;
        for (int d = 0; d < 2; d++) begin
            v = vote(d);
            mis = 1'b0;
            anyeq = 1'b0;
            for (int k = 0; k < nrep[d]; k++) begin
                if (m[d][k] != v) mis = 1'b1;
                else              anyeq = 1'b1;
            end
            if (rst) begin
                for (int k = 0; k < 7; k++) m[d][k] = '0;
                cnt[d] = 0;
                stk[d] = 1'b0;
            end else begin
                if (err_clr) begin
                    cnt[d] = 0;
                    stk[d] = 1'b0;
                end else begin
                    if (mis && cnt[d] < cmax[d]) cnt[d]++;
                    if (mis && !anyeq) stk[d] = 1'b1;
                end
                ridx = (d == 0) ? int'(inj_rep[2:0]) : int'(inj_rep);
                for (int k = 0; k < nrep[d]; k++) begin
                    nxt = scrub[d] ? v : m[d][k];
                    if (if_valid && instr_valid) nxt = {1'b1, instr, compr, illegal, 1'b0, pc};
                    else if (clear) begin
                        nxt[67] = 1'b0;
                        nxt[32] = ff;
                    end
                    if (inj_v && ridx == k) nxt ^= inj_mask;
                    m[d][k] = nxt;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [159:0] ev, ei, ec, el, ef, ep, efl;
        logic [67:0]  v, s;
        logic         anyeq;
        for (int d = 0; d < 2; d++) begin
            ev = '0; ei = '0; ec = '0; el = '0; ef = '0; ep = '0; efl = '0;
            anyeq = 1'b0;
            v = vote(d);
            for (int k = 0; k < nrep[d]; k++) begin
                s = vout[d] ? v : m[d][k];
                ev[k] = s[67];
                ei[k*32 +: 32] = s[66:35];
                ec[k] = s[34];
                el[k] = s[33];
                ef[k] = s[32];
                ep[k*32 +: 32] = s[31:0];
                efl[k] = (m[d][k] != v);
                if (m[d][k] == v) anyeq = 1'b1;
            end
            if (d == 0) begin
                chk("a_valid", 160'(a_valid), ev);
                chk("a_instr", 160'(a_instr), ei);
                chk("a_compr", 160'(a_compr), ec);
                chk("a_illegal", 160'(a_ill), el);
                chk("a_ff", 160'(a_ff), ef);
                chk("a_pc", 160'(a_pc), ep);
                chk("a_fault", 160'(a_fault), efl);
                chk("a_mismatch", 160'(a_mis), 160'(|efl));
                chk("a_uncorr", 160'(a_unc), 160'((|efl) && !anyeq));
                chk("a_sticky", 160'(a_stk), 160'(stk[0]));
                chk("a_cnt", 160'(a_cnt), 160'(cnt[0]));
            end else begin
                chk("b_valid", 160'(b_valid), ev);
                chk("b_instr", b_instr, ei);
                chk("b_compr", 160'(b_compr), ec);
                chk("b_illegal", 160'(b_ill), el);
                chk("b_ff", 160'(b_ff), ef);
                chk("b_pc", b_pc, ep);
                chk("b_fault", 160'(b_fault), efl);
                chk("b_mismatch", 160'(b_mis), 160'(|efl));
                chk("b_uncorr", 160'(b_unc), 160'((|efl) && !anyeq));
                chk("b_sticky", 160'(b_stk), 160'(stk[1]));
                chk("b_cnt", 160'(b_cnt), 160'(cnt[1]));
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        rst = 1'b0; if_valid = 1'b0; instr_valid = 1'b0; clear = 1'b0;
        err_clr = 1'b0; inj_v = 1'b0; ff = 1'b0;
    endtask

    task automatic load(input logic [31:0] i, input logic [31:0] p);
        if_valid = 1'b1; instr_valid = 1'b1; instr = i; pc = p; compr = 1'b0; illegal = 1'b0;
    endtask

    task automatic inject(input logic [3:0] r, input logic [67:0] msk);
        inj_v = 1'b1; inj_rep = r; inj_mask = msk;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 7; k++) m[d][k] = '0;
            cnt[d] = 0;
            stk[d] = 1'b0;
        end
        idle();
        instr = '0; pc = '0; compr = 1'b0; illegal = 1'b0; inj_rep = '0; inj_mask = '0;
        rst = 1'b1;
        cycle();
        cycle();
        chk("reset_a_valid", 160'(a_valid), 160'(0));
        chk("reset_b_cnt", 160'(b_cnt), 160'(0));

        idle(); load(32'h00A00093, 32'h80);
        cycle();
        chk("load_a_pc", 160'(a_pc), 160'({3{32'h80}}));
        chk("load_b_instr", b_instr, {5{32'h00A00093}});
        chk("load_a_valid", 160'(a_valid), 160'(3'b111));

        idle();
        cycle();
        clear = 1'b1; ff = 1'b1;
        cycle();
        chk("clear_a_ff", 160'(a_ff), 160'(3'b111));
        chk("clear_a_valid", 160'(a_valid), 160'(0));
        chk("clear_b_pc", b_pc, {5{32'h80}});

        load(32'h00A00093, 32'h80);
        cycle();
        chk("ldclr_a_valid", 160'(a_valid), 160'(3'b111));
        chk("ldclr_a_ff", 160'(a_ff), 160'(0));

        idle(); inject(4'd1, 68'h1);
        cycle();
        chk("inj_a_fault", 160'(a_fault), 160'(3'b010));
        chk("inj_a_raw_pc1", 160'(a_pc[63:32]), 160'(32'h81));
        chk("inj_b_fault", 160'(b_fault), 160'(5'b00010));
        idle();
        cycle();
        chk("scrub_a_mis", 160'(a_mis), 160'(0));
        chk("scrub_a_cnt", 160'(a_cnt), 160'(1));
        chk("scrub_a_pc", 160'(a_pc), 160'({3{32'h80}}));
        repeat (3) cycle();
        chk("sat_b_cnt", 160'(b_cnt), 160'(3));
        load(32'h00000013, 32'h84);
        cycle();
        chk("reload_b_fault", 160'(b_fault), 160'(0));

        idle(); inject(4'd0, 68'h1);
        cycle();
        inject(4'd2, 68'h2);
        cycle();
        chk("two_faults_b_unc", 160'(b_unc), 160'(0));
        inject(4'd1, 68'h4);
        cycle();
        inject(4'd3, 68'h8);
        cycle();
        inject(4'd4, 68'h10);
        cycle();
        chk("all_faulty_b_unc", 160'(b_unc), 160'(1));
        idle();
        cycle();
        chk("sticky_b_set", 160'(b_stk), 160'(1));
        err_clr = 1'b1;
        cycle();
        chk("clr_b_cnt", 160'(b_cnt), 160'(0));
        chk("clr_b_sticky", 160'(b_stk), 160'(0));

        idle(); load(32'h00A00093, 32'h80);
        cycle();
        idle(); inject(4'd0, 68'h10);
        cycle();
        inject(4'd3, 68'h10);
        cycle();
        chk("dbl_b_fault", 160'(b_fault), 160'(5'b01001));
        chk("dbl_b_pc", b_pc, {5{32'h80}});
        chk("dbl_b_unc", 160'(b_unc), 160'(0));
        inject(4'd6, 68'hF_FFFF_FFFF_FFFF_FFFF);
        cycle();
        chk("oor_b_fault", 160'(b_fault), 160'(5'b01001));

        idle(); rst = 1'b1; load(32'hDEADBEEF, 32'h100); inject(4'd1, 68'h1);
        cycle();
        chk("rst_mid_a_valid", 160'(a_valid), 160'(0));
        chk("rst_mid_b_pc", b_pc, 160'(0));

        for (int n = 0; n < 500; n++) begin
            idle();
            rst         = ($urandom_range(0, 49) == 0);
            if_valid    = $urandom_range(0, 1) == 1;
            instr_valid = $urandom_range(0, 3) != 0;
            clear       = $urandom_range(0, 3) == 0;
            instr       = $urandom;
            pc          = $urandom;
            compr       = $urandom_range(0, 1) == 1;
            illegal     = $urandom_range(0, 1) == 1;
            ff          = $urandom_range(0, 1) == 1;
            err_clr     = $urandom_range(0, 19) == 0;
            inj_v       = $urandom_range(0, 4) == 0;
            inj_rep     = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) inj_mask = 68'h1 << $urandom_range(0, 67);
            else                           inj_mask = {4'($urandom), $urandom, $urandom};
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
